// File: rtl/imm_pkg.sv
// Shared definitions for the immediate encoder: ctrl modes, FSM states and
// the constant table that the immediate decoder also indexes.
package imm_pkg;

    localparam logic [1:0] CTRL_LUT  = 2'b00;
    localparam logic [1:0] CTRL_SEXT = 2'b01;
    localparam logic [1:0] CTRL_UNS  = 2'b10;

    localparam int unsigned IMM_LUT_SIZE = 16;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CLASSIFY = 3'd1,
        SEARCH   = 3'd2,
        EMIT     = 3'd3,
        EMIT_HI  = 3'd4,
        EMIT_LO  = 3'd5
    } imm_state_e;

    // Entry 14 duplicates entry 1; the encoder always reports the lower index.
    localparam logic [7:0] IMM_LUT [0:IMM_LUT_SIZE-1] = '{
        8'h10, 8'h20, 8'h40, 8'h7F, 8'h7E, 8'h80, 8'hC0, 8'hE0,
        8'hF0, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h20, 8'h66
    };

endpackage

// File: rtl/imm_classify.sv
// Combinational detection of the direct immediate forms (2/4-bit, signed or
// unsigned); first match in priority order wins.
module imm_classify
    import imm_pkg::*;
(
    input  logic [7:0] value,
    output logic       match,
    output logic [1:0] ctrl,
    output logic       num_bits,
    output logic [1:0] imm0,
    output logic [1:0] imm1
);

    always_comb begin
        match    = 1'b0;
        ctrl     = CTRL_UNS;
        num_bits = 1'b0;
        imm0     = '0;
        imm1     = '0;
        if (value <= 8'h03) begin
            match = 1'b1;
            ctrl  = CTRL_UNS;
            imm1  = value[1:0];
        end else if (value >= 8'hFE) begin
            match = 1'b1;
            ctrl  = CTRL_SEXT;
            imm1  = value[1:0];
        end else if (value <= 8'h0F) begin
            match    = 1'b1;
            ctrl     = CTRL_UNS;
            num_bits = 1'b1;
            imm0     = value[3:2];
            imm1     = value[1:0];
        end else if (value >= 8'hF8) begin
            match    = 1'b1;
            ctrl     = CTRL_SEXT;
            num_bits = 1'b1;
            imm0     = value[3:2];
            imm1     = value[1:0];
        end
    end

endmodule

// File: rtl/imm_encoder.sv
// Encodes an 8-bit constant into one immediate word (direct or LUT index) or
// a two-word hi/lo unsigned split, with a valid/ready handshake on each side.
module imm_encoder
    import imm_pkg::*;
#(
    parameter int unsigned LUT_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_value,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] out_ctrl,
    output logic       out_numBits,
    output logic [1:0] out_imm0,
    output logic [1:0] out_imm1,
    output logic       out_split,
    output logic       out_last
);

    localparam logic [3:0] LAST_IDX = 4'(LUT_DEPTH - 1);

    imm_state_e state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic [7:0] value_q, value_d;
    logic       out_valid_q, out_valid_d;
    logic [1:0] out_ctrl_q, out_ctrl_d;
    logic       out_num_bits_q, out_num_bits_d;
    logic [1:0] out_imm0_q, out_imm0_d;
    logic [1:0] out_imm1_q, out_imm1_d;
    logic       out_split_q, out_split_d;
    logic       out_last_q, out_last_d;

    logic       cls_match;
    logic [1:0] cls_ctrl;
    logic       cls_num_bits;
    logic [1:0] cls_imm0;
    logic [1:0] cls_imm1;

    imm_classify u_classify (
        .value    (value_q),
        .match    (cls_match),
        .ctrl     (cls_ctrl),
        .num_bits (cls_num_bits),
        .imm0     (cls_imm0),
        .imm1     (cls_imm1)
    );

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        value_d        = value_q;
        out_valid_d    = out_valid_q;
        out_ctrl_d     = out_ctrl_q;
        out_num_bits_d = out_num_bits_q;
        out_imm0_d     = out_imm0_q;
        out_imm1_d     = out_imm1_q;
        out_split_d    = out_split_q;
        out_last_d     = out_last_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    value_d = in_value;
                    state_d = CLASSIFY;
                end
            end
            CLASSIFY: begin
                if (cls_match) begin
                    out_valid_d    = 1'b1;
                    out_ctrl_d     = cls_ctrl;
                    out_num_bits_d = cls_num_bits;
                    out_imm0_d     = cls_imm0;
                    out_imm1_d     = cls_imm1;
                    out_split_d    = 1'b0;
                    out_last_d     = 1'b1;
                    state_d        = EMIT;
                end else begin
                    idx_d   = '0;
                    state_d = SEARCH;
                end
            end
            SEARCH: begin
                if (IMM_LUT[idx_q] == value_q) begin
                    out_valid_d               = 1'b1;
                    out_ctrl_d                = CTRL_LUT;
                    out_num_bits_d            = 1'b1;
                    {out_imm0_d, out_imm1_d}  = idx_q;
                    out_split_d               = 1'b0;
                    out_last_d                = 1'b1;
                    state_d                   = EMIT;
                end else if (idx_q == LAST_IDX) begin
                    out_valid_d               = 1'b1;
                    out_ctrl_d                = CTRL_UNS;
                    out_num_bits_d            = 1'b1;
                    {out_imm0_d, out_imm1_d}  = value_q[7:4];
                    out_split_d               = 1'b1;
                    out_last_d                = 1'b0;
                    state_d                   = EMIT_HI;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            EMIT_HI: begin
                if (out_ready) begin
                    {out_imm0_d, out_imm1_d} = value_q[3:0];
                    out_last_d               = 1'b1;
                    state_d                  = EMIT_LO;
                end
            end
            EMIT_LO: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            value_q        <= '0;
            out_valid_q    <= 1'b0;
            out_ctrl_q     <= '0;
            out_num_bits_q <= 1'b0;
            out_imm0_q     <= '0;
            out_imm1_q     <= '0;
            out_split_q    <= 1'b0;
            out_last_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            value_q        <= value_d;
            out_valid_q    <= out_valid_d;
            out_ctrl_q     <= out_ctrl_d;
            out_num_bits_q <= out_num_bits_d;
            out_imm0_q     <= out_imm0_d;
            out_imm1_q     <= out_imm1_d;
            out_split_q    <= out_split_d;
            out_last_q     <= out_last_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = out_valid_q;
    assign out_ctrl    = out_ctrl_q;
    assign out_numBits = out_num_bits_q;
    assign out_imm0    = out_imm0_q;
    assign out_imm1    = out_imm1_q;
    assign out_split   = out_split_q;
    assign out_last    = out_last_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Randomized bench for imm_encoder against a form-search reference model.
module tb_imm_encoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_value = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [1:0] out_ctrl;
    logic       out_numBits;
    logic [1:0] out_imm0;
    logic [1:0] out_imm1;
    logic       out_split;
    logic       out_last;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Independent copy of the constant table shared with the decoder.
    logic [7:0] ref_lut [16] = '{
        8'h10, 8'h20, 8'h40, 8'h7F, 8'h7E, 8'h80, 8'hC0, 8'hE0,
        8'hF0, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h20, 8'h66
    };

    // Expected words packed as {ctrl[1:0], numBits, field[3:0], split, last}.
    logic [8:0] exp_q [$];
    int         exp_lat;

    imm_encoder #(.LUT_DEPTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_value    (in_value),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_ctrl    (out_ctrl),
        .out_numBits (out_numBits),
        .out_imm0    (out_imm0),
        .out_imm1    (out_imm1),
        .out_split   (out_split),
        .out_last    (out_last)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] observed();
        return {out_ctrl, out_numBits, out_imm0, out_imm1, out_split, out_last};
    endfunction

    // Try each direct form in priority order: does the value fit in a w-bit
    // unsigned/signed field? Else LUT search, else hi/lo unsigned split.
    task automatic model(input logic [7:0] v);
        int sv;
        int ctrl_t [4] = '{2, 1, 2, 1};
        int w_t    [4] = '{2, 2, 4, 4};
        bit done = 0;
        sv = (v >= 128) ? int'(v) - 256 : int'(v);
        exp_q.delete();
        for (int f = 0; f < 4 && !done; f++) begin
            int w = w_t[f];
            bit ok;
            if (ctrl_t[f] == 2) ok = (sv >= 0) && (sv < (1 << w));
            else                ok = (sv < 0) && (sv >= -(1 << (w - 1)));
            if (ok) begin
                logic [3:0] fld = 4'(int'(v) % (1 << w));
                exp_q.push_back({2'(ctrl_t[f]), (w == 4), fld, 1'b0, 1'b1});
                exp_lat = 2;
                done = 1;
            end
        end
        for (int k = 0; k < 16 && !done; k++) begin
            if (ref_lut[k] == v) begin
                exp_q.push_back({2'b00, 1'b1, 4'(k), 1'b0, 1'b1});
                exp_lat = k + 3;
                done = 1;
            end
        end
        if (!done) begin
            exp_q.push_back({2'b10, 1'b1, 4'(int'(v) / 16), 1'b1, 1'b0});
            exp_q.push_back({2'b10, 1'b1, 4'(int'(v) % 16), 1'b1, 1'b1});
            exp_lat = 16 + 2;
        end
    endtask

    // Offer v, measure latency, then consume each word after `stall` idle cycles.
    task automatic encode(input logic [7:0] v, input int stall);
        int n;
        logic [8:0] w;
        model(v);
        @(negedge clk);
        check_eq($sformatf("in_ready_idle_%02h", v), in_ready, 1'b1);
        in_valid = 1'b1;
        in_value = v;
        @(posedge clk);
        n = 1;
        #1 in_valid = 1'b0;
        @(negedge clk);
        while (!out_valid && n < 40) begin
            check_eq($sformatf("in_ready_busy_%02h", v), in_ready, 1'b0);
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check_eq($sformatf("latency_%02h", v), n, exp_lat);
        if (!out_valid) return;
        while (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            check_eq($sformatf("valid_%02h", v), out_valid, 1'b1);
            check_eq($sformatf("word_%02h", v), observed(), w);
            for (int s = 0; s < stall; s++) begin
                out_ready = 1'b0;
                @(posedge clk);
                @(negedge clk);
                check_eq($sformatf("hold_%02h", v), {out_valid, observed()}, {1'b1, w});
                check_eq($sformatf("hold_in_ready_%02h", v), in_ready, 1'b0);
            end
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            out_ready = 1'b0;
        end
        check_eq($sformatf("done_valid_%02h", v), out_valid, 1'b0);
        check_eq($sformatf("done_in_ready_%02h", v), in_ready, 1'b1);
    endtask

    logic [7:0] directed [14] = '{
        8'h03, 8'hFA, 8'hFF, 8'h80, 8'h00, 8'h04, 8'h0F, 8'hF8,
        8'hFD, 8'hFE, 8'h10, 8'h20, 8'h66, 8'hF7
    };

    initial begin
        #2;
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_in_ready", in_ready, 1'b1);
        check_eq("rst_fields", {out_ctrl, out_numBits, out_imm0, out_imm1, out_split, out_last}, '0);
        #20 rst_n = 1'b1;

        foreach (directed[i]) encode(directed[i], i % 2);
        encode(8'h5A, 5);

        // Reset while SEARCH is at index 3 (after the 5th edge from accept).
        @(negedge clk);
        in_valid = 1'b1;
        in_value = 8'h5A;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_out_valid", out_valid, 1'b0);
        check_eq("midrst_in_ready", in_ready, 1'b1);
        #2 rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check_eq("midrst_no_word", out_valid, 1'b0);
        end
        encode(8'h80, 0);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] v;
            if ($urandom_range(0, 2) == 0) v = ref_lut[$urandom_range(0, 15)];
            else                           v = 8'($urandom_range(0, 255));
            encode(v, $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 SHALL have parameter LUT_DEPTH, default 16, meaning the number of IMM_LUT entries searched (legal range 1..16).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  an 8-bit constant is offered.
REQ-005 SHALL have port in_ready  output  1  block accepts a constant (high only in IDLE).
REQ-006 SHALL have port in_value  input  8  constant to encode.
REQ-007 SHALL have port out_valid  output  1  an encoded immediate word is presented.
REQ-008 SHALL have port out_ready  input  1  consumer takes the word.
REQ-009 SHALL have port out_ctrl  output  2  immediate mode: 00 LUT, 01 sign-extend, 10 unsigned.
REQ-010 SHALL have port out_numBits  output  1  0 = 2-bit immediate, 1 = 4-bit immediate.
REQ-011 SHALL have port out_imm0  output  2  upper operand field.
REQ-012 SHALL have port out_imm1  output  2  lower operand field.
REQ-013 SHALL have port out_split  output  1  word is part of a two-word hi/lo sequence.
REQ-014 SHALL have port out_last  output  1  final word for the current constant.

Function
REQ-015 SHALL be the inverse of the immediate decoder: the emitted fields, decoded as {imm0,imm1} (numBits=1) or {imm1} (numBits=0), zero- or sign-extended, or used as a LUT index, SHALL reproduce in_value.
REQ-016 SHALL implement the states IDLE, CLASSIFY, SEARCH, EMIT, EMIT_HI and EMIT_LO.
REQ-017 SHALL accept a constant on an edge where state is IDLE and in_valid=1, register it, and enter CLASSIFY.
REQ-018 In CLASSIFY, SHALL select the first matching form in this order: 0x00-0x03 -> ctrl 10, numBits 0; 0xFE-0xFF -> ctrl 01, numBits 0; 0x04-0x0F -> ctrl 10, numBits 1; 0xF8-0xFD -> ctrl 01, numBits 1.
REQ-019 On a match in CLASSIFY, SHALL enter EMIT with out_last=1 and out_split=0; otherwise SHALL enter SEARCH with index 0.
REQ-020 SEARCH SHALL compare one IMM_LUT entry per cycle, starting at index 0 and incrementing the index.
REQ-021 On the first hit at index k, SHALL enter EMIT with ctrl 00, numBits 1 and {imm0,imm1}=k.
REQ-022 On a miss at index LUT_DEPTH-1, SHALL enter EMIT_HI.
REQ-023 Latency, counted from the accept edge, SHALL be: direct forms, out_valid high after the 2nd edge; LUT hit at index k, after edge k+3; split, EMIT_HI valid after edge LUT_DEPTH+2.
REQ-024 EMIT_HI SHALL present ctrl 10, numBits 1, fields = value[7:4], out_split=1, out_last=0.
REQ-025 EMIT_LO SHALL present ctrl 10, numBits 1, fields = value[3:0], out_split=1, out_last=1; the consumer reconstructs the value as (hi<<4)|lo.
REQ-026 All out_* signals SHALL be registered and SHALL hold stable while out_valid=1 and out_ready=0.
REQ-027 On an edge with out_valid=1 and out_ready=1: EMIT SHALL return to IDLE, EMIT_HI SHALL go to EMIT_LO, and EMIT_LO SHALL go to IDLE.
REQ-028 SHALL not accept a new constant in the same cycle as the final handshake; in_ready rises only once state is IDLE.
REQ-029 out_valid SHALL be 0 in IDLE, CLASSIFY and SEARCH.
REQ-030 If the LUT contains duplicate entries, the lowest index SHALL win.

Reset
REQ-031 While rst_n=0, SHALL force state to IDLE, SEARCH index to 0, out_valid/out_split/out_last to 0, all output fields to 0 and the captured value to 0.
REQ-032 SHALL present in_ready=1 immediately on reset (IDLE).
REQ-033 Reset asserted mid-SEARCH or mid-EMIT_HI/EMIT_LO SHALL abandon the constant with no further words emitted.

Structure
REQ-034 Package imm_pkg SHALL hold the ctrl mode constants (LUT=00, SEXT=01, UNS=10), the FSM state enum, and IMM_LUT (16 x 8-bit table shared with the decoder).
REQ-035 SHALL contain one combinational sub-module, imm_classify, mapping an 8-bit value to {match, ctrl, numBits, imm0, imm1} for the direct forms.

Verification
REQ-036 SHALL cover: in_value=0x03, out_ready=1 -> one word {10,0,00,11}, last=1, out_valid after 2nd edge.
REQ-037 SHALL cover: in_value=0xFA -> one word {01,1,10,10}, last=1; in_value=0xFF -> {01,0,00,11}.
REQ-038 SHALL cover: IMM_LUT[5]=0x80, in_value=0x80 -> {00,1,01,01}, last=1, out_valid after edge 8.
REQ-039 SHALL cover: 0x5A absent from the LUT -> hi {10,1,01,01} split=1 last=0, then lo {10,1,10,10} split=1 last=1.
REQ-040 SHALL cover: out_ready held 0 for 5 cycles on the hi word -> outputs unchanged and in_ready=0 throughout.
REQ-041 SHALL cover: rst_n pulsed low during SEARCH index 3 -> out_valid=0 and in_ready=1 at once, and the next constant is encoded correctly.
